// File: rtl/core_clock_controller_pkg.sv
// Shared definitions for the core clock controller: FSM state encoding and mode button levels.
package core_clock_controller_pkg;

  typedef enum logic [1:0] {
    CLK_LOW  = 2'd0,
    CLK_HIGH = 2'd1,
    CLK_HOLD = 2'd2
  } clk_state_t;

  localparam logic CLOCK_MODE_STEP = 1'b0;
  localparam logic CLOCK_MODE_FREE = 1'b1;

endpackage

// File: rtl/button_debouncer.sv
// Step button conditioning: 2-FF synchroniser, debounce counter, one-cycle press on the rising edge.
// Debounce filtering is active only when STEP_DEBOUNCE_EN is defined; otherwise the threshold collapses to zero.
module button_debouncer
  import core_clock_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef STEP_DEBOUNCE_EN
  localparam int LIMIT = DEBOUNCE_CYCLES;
`else
  localparam int LIMIT = 0;
`endif

  logic          sync_meta;
  logic          sync_level;
  logic          db;
  logic          db_prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta  <= 1'b0;
      sync_level <= 1'b0;
      db         <= 1'b0;
      db_prev    <= 1'b0;
      cnt        <= '0;
    end else begin
      sync_meta  <= button;
      sync_level <= sync_meta;
      db_prev    <= db;
      // Any return to the accepted level restarts the stability window.
      if (sync_level == db) begin
        cnt <= '0;
      end else if (cnt == CW'(LIMIT)) begin
        db  <= sync_level;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = db & ~db_prev;

endmodule

// File: rtl/core_clock_controller.sv
// Core clock generator with free-run / single-step / stall control and a 64-bit millisecond timebase.
// Optional step debouncing is enabled by defining STEP_DEBOUNCE_EN.
module core_clock_controller
  import core_clock_controller_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ = 50000000,
  parameter int CORE_DIV      = 2,
  parameter int DEBOUNCE_MS   = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clock_mode_button,
  input  logic        step_button,
  input  logic        stall_core,
  output logic        core_clock,
  output logic [63:0] miliseconds
);

  localparam int TICKS = CLOCK_FREQ_HZ / 1000;
  localparam int HALF  = CORE_DIV / 2;
  localparam int PW    = $clog2(TICKS + 1);
  localparam int HW    = $clog2(HALF + 1);

  logic [PW-1:0] prescaler;
  logic          mode_meta;
  logic          mode;
  logic          press;
  clk_state_t    state;
  logic [HW-1:0] phase_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescaler   <= '0;
      miliseconds <= '0;
    end else if (prescaler == PW'(TICKS - 1)) begin
      prescaler   <= '0;
      miliseconds <= miliseconds + 64'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_meta <= 1'b0;
      mode      <= 1'b0;
    end else begin
      mode_meta <= clock_mode_button;
      mode      <= mode_meta;
    end
  end

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_MS * TICKS)
  ) u_step (
    .clock (clock),
    .reset (reset),
    .button(step_button),
    .press (press)
  );

  // A high phase always runs to completion; stall and mode are only consulted at the end of LOW or in HOLD.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= CLK_HOLD;
      phase_cnt  <= '0;
      core_clock <= 1'b0;
    end else begin
      case (state)
        CLK_LOW: begin
          if (phase_cnt == HW'(HALF - 1)) begin
            phase_cnt <= '0;
            if (mode == CLOCK_MODE_STEP || stall_core) begin
              state <= CLK_HOLD;
            end else begin
              state      <= CLK_HIGH;
              core_clock <= 1'b1;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        CLK_HIGH: begin
          if (phase_cnt == HW'(HALF - 1)) begin
            phase_cnt  <= '0;
            state      <= CLK_LOW;
            core_clock <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        CLK_HOLD: begin
          if (press || (mode == CLOCK_MODE_FREE && !stall_core)) begin
            state      <= CLK_HIGH;
            phase_cnt  <= '0;
            core_clock <= 1'b1;
          end
        end
        default: begin
          state      <= CLK_HOLD;
          phase_cnt  <= '0;
          core_clock <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_clock_controller.sv
// Bench for core_clock_controller: directed vector table, corner-case sequences, randomized run against a reference model.
module tb_core_clock_controller;

  localparam int TICKS = 10;
  localparam int HALF  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mode  = 1'b0;
  logic        step  = 1'b0;
  logic        stall = 1'b0;
  logic        core_clock;
  logic [63:0] ms;

  int errors = 0;
  int checks = 0;

  // Reference model: elapsed cycles, remaining high/low phase cycles, input history (index 0 = current edge).
  int cyc_cnt = 0;
  int hi_left = 0;
  int lo_left = 0;
  bit sh[0:4];
  bit mh[0:2];

  typedef struct {
    logic   mode;
    logic   stall;
    int     ncyc;
    logic   exp_core;
    longint exp_ms;
  } vec_t;
  vec_t vt[12];

  core_clock_controller #(
    .CLOCK_FREQ_HZ(10000),
    .CORE_DIV     (4),
    .DEBOUNCE_MS  (2)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .clock_mode_button(mode),
    .step_button      (step),
    .stall_core       (stall),
    .core_clock       (core_clock),
    .miliseconds      (ms)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    cyc_cnt = 0;
    hi_left = 0;
    lo_left = 0;
    for (int i = 0; i < 5; i++) sh[i] = 1'b0;
    for (int i = 0; i < 3; i++) mh[i] = 1'b0;
  endtask

  // One reference cycle: advance model at the rising edge, return at the falling edge.
  task automatic cyc();
    bit press_m;
    bit mode_m;
    @(posedge clock);
    if (!reset) begin
      model_clear();
    end else begin
      for (int i = 4; i > 0; i--) sh[i] = sh[i-1];
      sh[0] = step;
      for (int i = 2; i > 0; i--) mh[i] = mh[i-1];
      mh[0] = mode;
      press_m = sh[3] & ~sh[4];
      mode_m  = mh[2];
      cyc_cnt++;
      if (hi_left > 0) begin
        hi_left--;
        if (hi_left == 0) lo_left = HALF;
      end else if (lo_left > 0) begin
        lo_left--;
        if (lo_left == 0 && mode_m && !stall) hi_left = HALF;
      end else if (press_m || (mode_m && !stall)) begin
        hi_left = HALF;
      end
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    int n;
    int highs;
    model_clear();

    #2 reset = 1'b0;
    #1;
    check("reset_core_async", core_clock, 1'b0);
    check("reset_ms_async", ms, 64'd0);

    vt[0]  = '{1'b0, 1'b0,   9, 1'b0, 64'd0};
    vt[1]  = '{1'b0, 1'b0,  10, 1'b0, 64'd1};
    vt[2]  = '{1'b0, 1'b0,  20, 1'b0, 64'd2};
    vt[3]  = '{1'b0, 1'b0, 105, 1'b0, 64'd10};
    vt[4]  = '{1'b1, 1'b0,   2, 1'b0, 64'd0};
    vt[5]  = '{1'b1, 1'b0,   3, 1'b1, 64'd0};
    vt[6]  = '{1'b1, 1'b0,   4, 1'b1, 64'd0};
    vt[7]  = '{1'b1, 1'b0,   5, 1'b0, 64'd0};
    vt[8]  = '{1'b1, 1'b0,   7, 1'b1, 64'd0};
    vt[9]  = '{1'b1, 1'b0,  11, 1'b1, 64'd1};
    vt[10] = '{1'b1, 1'b1,   3, 1'b0, 64'd0};
    vt[11] = '{1'b1, 1'b1,  50, 1'b0, 64'd5};

    for (int i = 0; i < 12; i++) begin
      mode  = vt[i].mode;
      stall = vt[i].stall;
      step  = 1'b0;
      do_reset();
      repeat (vt[i].ncyc) cyc();
      check($sformatf("vec%0d_core", i), core_clock, vt[i].exp_core);
      check($sformatf("vec%0d_ms", i), ms, vt[i].exp_ms);
    end

    // Stall raised in the first high cycle: that pulse completes, then the clock freezes low.
    mode  = 1'b1;
    stall = 1'b0;
    do_reset();
    n = 0;
    while (core_clock !== 1'b1 && n < 10) begin cyc(); n++; end
    check("stall_first_rise", core_clock, 1'b1);
    stall = 1'b1;
    cyc();
    check("stall_high_completes", core_clock, 1'b1);
    cyc();
    check("stall_fall", core_clock, 1'b0);
    highs = 0;
    repeat (100) begin cyc(); if (core_clock === 1'b1) highs++; end
    check("stall_frozen_highs", highs, 0);
    stall = 1'b0;
    n = 0;
    while (core_clock !== 1'b1 && n < 2) begin cyc(); n++; end
    check("stall_release_rise", core_clock, 1'b1);

    // Step mode: each press gives one two-cycle pulse; a press during a pulse is dropped.
    mode  = 1'b0;
    stall = 1'b0;
    step  = 1'b0;
    do_reset();
    repeat (5) cyc();
`ifndef STEP_DEBOUNCE_EN
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      n = 0;
      while (core_clock !== 1'b1 && n < 10) begin cyc(); step = 1'b0; n++; end
      check($sformatf("step%0d_latency", p), n, 4);
      step = 1'b1;
      highs = 0;
      for (int c = 0; c < 19; c++) begin
        cyc();
        step = 1'b0;
        if (core_clock === 1'b1) highs++;
      end
      check($sformatf("step%0d_extra_highs", p), highs, 1);
    end
`else
    for (int b = 0; b < 3; b++) begin
      step = 1'b1;
      repeat (5) cyc();
      step = 1'b0;
      repeat (5) cyc();
    end
    check("bounce_no_pulse", core_clock, 1'b0);
    step = 1'b1;
    n = 0;
    while (core_clock !== 1'b1 && n < 40) begin cyc(); n++; end
    check("debounce_latency", n, 24);
    highs = 0;
    repeat (40) begin cyc(); if (core_clock === 1'b1) highs++; end
    check("debounce_single_pulse", highs, 1);
    step = 1'b0;
    repeat (30) cyc();
`endif

    // Reset mid-pulse clears outputs without waiting for an edge.
    mode  = 1'b1;
    stall = 1'b0;
    step  = 1'b0;
    do_reset();
    repeat (30) cyc();
    n = 0;
    while (core_clock !== 1'b1 && n < 6) begin cyc(); n++; end
    check("midpulse_high", core_clock, 1'b1);
    check("midpulse_ms_before", ms, 64'd3);
    reset = 1'b0;
    #1;
    check("midpulse_core_async", core_clock, 1'b0);
    check("midpulse_ms_async", ms, 64'd0);
    cyc();
    reset = 1'b1;

    // Randomized run against the reference model.
    mode  = 1'b1;
    stall = 1'b0;
    step  = 1'b0;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      if ($urandom_range(0, 11) == 0) stall = ~stall;
`ifndef STEP_DEBOUNCE_EN
      if ($urandom_range(0, 5) == 0) step = ~step;
`endif
      cyc();
      check($sformatf("rand%0d_core", k), core_clock, (hi_left > 0) ? 64'd1 : 64'd0);
      check($sformatf("rand%0d_ms", k), ms, 64'(cyc_cnt / TICKS));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
